// File: rtl/pkt_rr_arb.sv
// pkt_rr_arb: round-robin packet arbiter; grants one port per packet onto a registered output bus
module pkt_rr_arb #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_vld,
  input  logic [NUM_IN-1:0]        in_sop,
  input  logic [NUM_IN-1:0]        in_eop,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_rdy,
  output logic                     out_vld,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_rdy,
  output logic [15:0]              out_pkt_cnt,
  output logic                     err_sop
);
  localparam int IW = $clog2(NUM_IN);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
  logic first_q, first_d, out_vld_q, out_vld_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d, err_q, err_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
  logic [15:0] cnt_q, cnt_d;
  logic [NUM_IN-1:0] elig, rot;
  logic found, rdy, acc;
  int sum;
  assign elig = in_vld & in_sop;
  assign found = |elig;
  // rotate so bit 0 is the port at rr_ptr; the lowest set bit wins
  assign rot = NUM_IN'({elig, elig} >> rr_ptr_q);
  always_comb begin
    pick = rr_ptr_q;
    sum = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(rr_ptr_q) + k;
        pick = IW'(sum >= NUM_IN ? sum - NUM_IN : sum);
      end
    end
  end
  assign rdy = !out_vld_q || out_rdy;
  assign acc = (state_q == XFER) && in_vld[grant_q] && rdy;
  assign sel_data = in_data[int'(grant_q)*DATA_W +: DATA_W];
  assign in_rdy = (state_q == XFER) ? NUM_IN'(rdy) << grant_q : '0;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    first_d = first_q;
    out_vld_d = out_vld_q && !out_rdy;
    out_sop_d = out_sop_q;
    out_eop_d = out_eop_q;
    out_data_d = out_data_q;
    err_d = err_q || (acc && in_sop[grant_q] && !first_q);
    cnt_d = cnt_q + 16'(out_vld_q & out_rdy & out_eop_q);
    if (state_q == IDLE && found) begin
      state_d = XFER;
      grant_d = pick;
      first_d = 1'b1;
    end
    if (acc) begin
      out_vld_d = 1'b1;
      out_sop_d = in_sop[grant_q];
      out_eop_d = in_eop[grant_q];
      out_data_d = sel_data;
      first_d = 1'b0;
      state_d = in_eop[grant_q] ? IDLE : XFER;
      rr_ptr_d = !in_eop[grant_q] ? rr_ptr_q : (grant_q == IW'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      first_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_data_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q <= first_d;
      out_vld_q <= out_vld_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
      out_data_q <= out_data_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign out_vld = out_vld_q;
  assign out_sop = out_sop_q;
  assign out_eop = out_eop_q;
  assign out_data = out_data_q;
  assign out_pkt_cnt = cnt_q;
  assign err_sop = err_q;
endmodule

// File: tb/tb_pkt_rr_arb.sv
// tb_pkt_rr_arb: arbitration vector table plus scoreboarded packet sequences for pkt_rr_arb
module tb_pkt_rr_arb;
  localparam int N = 4, W = 8;
  typedef struct packed {logic sop; logic eop; logic [W-1:0] data;} beat_t;
  typedef struct {logic [N-1:0] vld; logic [N-1:0] sop; int win;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] in_vld = '0, in_sop = '0, in_eop = '0, in_rdy;
  logic [N*W-1:0] in_data = '0;
  logic out_vld, out_sop, out_eop, out_rdy = 1'b1, err_sop;
  logic [W-1:0] out_data;
  logic [15:0] out_pkt_cnt;
  int total = 0, bad = 0, cyc_n = 0, hs_n = 0;
  beat_t pq [N][$];
  beat_t exp_q [$];
  int hs_t [$];
  logic [N-1:0] acc = '0;
  logic ordy = 1'b1, pend_cnt = 1'b0;
  logic [15:0] cnt_m = '0;
  vec_t tv [9];

  pkt_rr_arb #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_rdy(in_rdy), .out_vld(out_vld), .out_sop(out_sop),
    .out_eop(out_eop), .out_data(out_data), .out_rdy(out_rdy),
    .out_pkt_cnt(out_pkt_cnt), .err_sop(err_sop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input int p, input int nb, input logic [W-1:0] base, input int sop2);
    beat_t x;
    for (int b = 0; b < nb; b++) begin
      x.sop = (b == 0) || (b == sop2);
      x.eop = (b == nb - 1);
      x.data = base + W'(b);
      pq[p].push_back(x);
      exp_q.push_back(x);
    end
  endtask

  task automatic step();
    beat_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    out_rdy = ordy;
    for (int i = 0; i < N; i++) begin
      in_vld[i] = pq[i].size() > 0;
      in_sop[i] = in_vld[i] && pq[i][0].sop;
      in_eop[i] = in_vld[i] && pq[i][0].eop;
      in_data[i*W +: W] = in_vld[i] ? pq[i][0].data : '0;
    end
    #1;
    if (pend_cnt) begin
      chk("pkt_cnt", 32'(out_pkt_cnt), 32'(cnt_m));
      pend_cnt = 1'b0;
    end
    if (out_vld && out_rdy) begin
      hs_n++;
      hs_t.push_back(cyc_n);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h want none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 32'({out_sop, out_eop, out_data}), 32'(e));
        if (e.eop) begin
          cnt_m++;
          pend_cnt = 1'b1;
        end
      end
    end
    acc = in_vld & in_rdy;
  endtask

  task automatic drain(input string name, input int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      step();
      n++;
    end
    step();
    step();
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = '0;
  endtask

  initial begin
    int base, n;
    tv[0] = '{4'b0001, 4'b0000, -1};
    tv[1] = '{4'b1001, 4'b1000, 3};
    tv[2] = '{4'b0001, 4'b0001, 0};
    tv[3] = '{4'b1111, 4'b1111, 1};
    tv[4] = '{4'b0011, 4'b0011, 0};
    tv[5] = '{4'b0100, 4'b0100, 2};
    tv[6] = '{4'b0101, 4'b0101, 0};
    tv[7] = '{4'b1100, 4'b1100, 2};
    tv[8] = '{4'b1100, 4'b1100, 3};
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 32'({in_rdy, out_vld, out_sop, out_eop, out_data, out_pkt_cnt, err_sop}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // single-beat arbitration vectors; rr_ptr carries over from row to row
    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      in_vld = tv[r].vld;
      in_sop = tv[r].sop;
      in_eop = tv[r].sop;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA3 + W'(i);
      #1 chk("idle_rdy", 32'(in_rdy), 32'd0);
      @(negedge clk);
      #1 chk("grant_rdy", 32'(in_rdy), (tv[r].win < 0) ? 32'd0 : 32'd1 << tv[r].win);
      @(negedge clk);
      in_vld = '0;
      in_sop = '0;
      in_eop = '0;
      #1;
      if (tv[r].win >= 0) begin
        chk("row_beat", 32'({out_vld, out_sop, out_eop, out_data}), 32'({3'b111, W'(8'hA3 + tv[r].win)}));
        cnt_m++;
      end else chk("row_none", 32'(out_vld), 32'd0);
      @(negedge clk);
      #1 chk("row_drain", 32'({out_vld, in_rdy}), 32'd0);
      chk("row_cnt", 32'(out_pkt_cnt), 32'(cnt_m));
    end
    pulse_reset();
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) load(p, 3, W'(p*16 + r*4), -1);
    hs_t.delete();
    drain("rr_order", 100);
    chk("rr_span", (hs_t.size() >= 15) ? 32'(hs_t[14] - hs_t[0]) : 32'hFFFF_FFFF, 32'd18);
    chk("rr_cnt", 32'(out_pkt_cnt), 32'd8);
    load(1, 5, 8'h50, -1);
    base = hs_n;
    n = 0;
    while (hs_n < base + 2 && n < 40) begin
      step();
      n++;
    end
    ordy = 1'b0;
    repeat (4) begin
      step();
      chk("stall_out", 32'({out_vld, out_sop, out_eop, out_data}), 32'({1'b1, exp_q[0]}));
      chk("stall_rdy", 32'(in_rdy), 32'd0);
    end
    ordy = 1'b1;
    drain("stall", 50);
    chk("err_pre", 32'(err_sop), 32'd0);
    load(2, 3, 8'h70, 1);
    drain("sop_err", 50);
    chk("err_set", 32'(err_sop), 32'd1);
    repeat (3) step();
    chk("err_sticky", 32'(err_sop), 32'd1);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    cnt_m = 16'hFFFF;
    #1 chk("cnt_forced", 32'(out_pkt_cnt), 32'h0000_FFFF);
    load(0, 1, 8'h90, -1);
    drain("wrap", 20);
    chk("cnt_wrap", 32'(out_pkt_cnt), 32'd0);
    load(1, 4, 8'hB0, -1);
    base = hs_n;
    n = 0;
    while (hs_n < base + 1 && n < 20) begin
      step();
      n++;
    end
    chk("err_keep", 32'(err_sop), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({in_rdy, out_vld, out_sop, out_eop, out_data, out_pkt_cnt, err_sop}), 32'd0);
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    acc = '0;
    pend_cnt = 1'b0;
    cnt_m = '0;
    in_vld = '0;
    in_sop = '0;
    in_eop = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(0, 1, 8'hC0, -1);
    load(2, 1, 8'hC2, -1);
    drain("post_rst", 30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
